tb_mmio_console: RTL and testbench
==================================

// Module: tb_mmio_console
// PURPOSE
//  Memory-mapped console/exit peripheral on the cv32e40p data bus, decoded at MMIO_ADDR.
//  - Accepts EXIT and PRINT stores from the core and buffers printed characters in a FIFO.
//  - Drains the FIFO to a char stream (valid/ready) consumed by the bench's $write sink.
//  - Raises a sticky exit flag with the error code once all buffered characters are drained.
//  - Provides the data_gnt/data_rvalid/data_rdata response for the MMIO region.
// PARAMETERS
//  BASE_ADDR   32'h8000_0000  base of the 16-byte register window
//  FIFO_DEPTH  16             print FIFO entries; power of two, >= 2
//  CNT_W       32             cycle counter width, 1..32
// PORTS
//  clk_i          in   1   clock; all logic on its rising edge
//  rst_i          in   1   synchronous reset, active high
//  req_i          in   1   core data request
//  addr_i         in   32  byte address
//  we_i           in   1   1 = store, 0 = load
//  be_i           in   4   byte enables
//  wdata_i        in   32  store data
//  gnt_o          out  1   request accepted (combinational)
//  rvalid_o       out  1   response valid, loads and stores
//  rdata_o        out  32  load data; 0 on stores
//  char_valid_o   out  1   FIFO head valid
//  char_o         out  8   FIFO head character
//  char_ready_i   in   1   sink accepts char_o
//  exit_valid_o   out  1   sticky: exit written and FIFO drained
//  exit_code_o    out  32  value written to EXIT
// BEHAVIOUR
//  Decode
//  - sel = req_i & (addr_i[31:4] == BASE_ADDR[31:4]); offset = addr_i[3:2].
//  - Requests with !sel are ignored: no gnt, no rvalid.
//  Register map
//  - +0x0 EXIT:   write latches wdata_i into exit_code; reads return exit_code.
//  - +0x4 PRINT:  write pushes wdata_i[7:0] if be_i[0]; be_i[0]=0 means accepted but no push.
//                 Reads return the free FIFO entry count.
//  - +0x8 CYCLE:  read-only, zero-extended cycle counter; writes accepted and ignored.
//  - +0xC STATUS: read-only, {29'b0, exit_valid, fifo_full, fifo_empty}.
//  Handshake
//  - gnt_o = sel & ~(we_i & offset==1 & fifo_full), where fifo_full is registered state.
//  - No same-cycle pop bypass: a full FIFO stalls the store even while a pop occurs.
//  - On accept (sel & gnt_o): rvalid_o=1 and rdata_o are valid exactly one cycle later.
//  - Back-to-back accepts give back-to-back rvalids. There is no other latency.
//  FIFO
//  - Push on accepted PRINT store with be_i[0]; pop when char_valid_o & char_ready_i.
//  - Registered head, no fall-through: a push into an empty FIFO shows char_valid_o the next cycle.
//  - Simultaneous push and pop when not full keeps occupancy constant.
//  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
//  State machine
//  - RUN:   the first accepted EXIT store latches exit_code and goes to DRAIN.
//  - DRAIN: further EXIT stores are accepted, but exit_code is unchanged (first write wins).
//           PRINT pushes are still allowed. Go to DONE in the cycle the FIFO is empty.
//  - DONE:  exit_valid_o=1 and held; the cycle counter freezes; stores are accepted and ignored.
//           Only reset leaves DONE.
//  - The DRAIN->DONE transition is evaluated on registered occupancy, so it occurs one cycle
//    after the last pop.
//  Counter
//  - Increments every cycle in RUN and DRAIN; wraps modulo 2^CNT_W.
//  Reset
//  - Clears FIFO, counter, exit_code and rdata_o, and sets state RUN.
//  - Outputs after reset: gnt_o follows its equation, rvalid_o=0, char_valid_o=0,
//    exit_valid_o=0.
//  - Reset mid-transaction drops any pending rvalid and all buffered characters.
// TESTING
//  1. Store 'H','i' to 0x8000_0004, ready=1: char_o 0x48 then 0x69, one per cycle,
//     each rvalid 1 cycle after gnt.
//  2. Ready=0, 17 PRINT stores, DEPTH=16: 16 accepted; the 17th sees gnt_o=0 until one
//     ready pulse, then is accepted next cycle.
//  3. Push 3 chars, ready=0, store 0 to EXIT: state DRAIN, exit_valid_o=0.
//     Raise ready: exit_valid_o=1 one cycle after the 3rd pop, exit_code_o=0.
//  4. EXIT 5 then EXIT 7 before drain: exit_code_o=5; loads of STATUS read 0x5
//     (exit_valid, empty) in DONE.
//  5. Load 0x8000_0008 twice 10 cycles apart: values differ by 10. In DONE, repeated
//     loads return an identical value.
//  6. Assert rst_i with 4 chars buffered and a load pending: next cycle rvalid_o=0,
//     char_valid_o=0, STATUS=0x1.

Source files
------------

// File: rtl/tb_mmio_console.sv
// Memory-mapped console/exit peripheral: EXIT/PRINT/CYCLE/STATUS window with a print FIFO.
module tb_mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             exit_load;
    logic             sel;
    logic [1:0]       offset;
    logic             accept;
    logic             push;
    logic             pop;
    logic [PTR_W:0]   wr_ptr, rd_ptr, count;
    logic             fifo_empty, fifo_full;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [CNT_W-1:0] cycle_cnt;
    logic [31:0]      rd_val;
    logic             unused;

    // Address decode, handshake and FIFO status from registered pointers
    assign sel        = req_i & (addr_i[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr_i[3:2];
    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_V);
    assign gnt_o      = sel & ~(we_i & (offset == 2'd1) & fifo_full);
    assign accept     = sel & gnt_o;
    assign push       = accept & we_i & (offset == 2'd1) & be_i[0] & (state != DONE);
    assign pop        = char_valid_o & char_ready_i;
    assign char_valid_o = ~fifo_empty;
    assign char_o       = mem[rd_ptr[PTR_W-1:0]];
    assign unused       = ^{addr_i[1:0], be_i[3:1]};

    // Next-state logic: first EXIT store starts the drain, drain ends on empty FIFO
    always_comb begin
        state_n   = state;
        exit_load = 1'b0;
        case (state)
            RUN: begin
                if (accept && we_i && (offset == 2'd0)) begin
                    state_n   = DRAIN;
                    exit_load = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = DONE;
            default: state_n = RUN;
        endcase
    end

    // Load data mux for the register window
    always_comb begin
        rd_val = '0;
        case (offset)
            2'd0: rd_val = exit_code_o;
            2'd1: rd_val = 32'(DEPTH_V - count);
            2'd2: rd_val = 32'(cycle_cnt);
            2'd3: rd_val = {29'b0, exit_valid_o, fifo_full, fifo_empty};
            default: rd_val = '0;
        endcase
    end

    // State, pointers, counter and bus response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cycle_cnt    <= '0;
            exit_code_o  <= '0;
            exit_valid_o <= 1'b0;
            rvalid_o     <= 1'b0;
            rdata_o      <= '0;
        end else begin
            state        <= state_n;
            exit_valid_o <= (state_n == DONE);
            if (exit_load) begin
                exit_code_o <= wdata_i;
            end
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
            if (state != DONE) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            rvalid_o <= accept;
            if (accept) begin
                rdata_o <= we_i ? 32'h0 : rd_val;
            end
        end
    end

    // FIFO storage, no reset needed since pointers qualify it
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wdata_i[7:0];
        end
    end

endmodule

// File: tb/tb_tb_mmio_console.sv
// Directed self-checking bench for the MMIO console peripheral.
module tb_tb_mmio_console;

    localparam logic [31:0] A_EXIT   = 32'h8000_0000;
    localparam logic [31:0] A_PRINT  = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = '0;
    logic        gnt_o, rvalid_o, char_valid_o, exit_valid_o;
    logic [31:0] rdata_o, exit_code_o;
    logic [7:0]  char_o;
    logic        char_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    tb_mmio_console dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .char_ready_i (char_ready),
        .exit_valid_o (exit_valid_o),
        .exit_code_o  (exit_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; called just after a rising edge, returns just after the response edge
    task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd);
        int n;
        n = 0;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        while (!gnt_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!gnt_o) check("gnt_timeout", 32'(gnt_o), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check("rvalid", 32'(rvalid_o), 32'd1);
        rd = rdata_o;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [31:0] rd, rd2;
    int          n;

    initial begin
        do_reset();

        // reset state
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_char_valid", 32'(char_valid_o), 32'd0);
        check("rst_exit_valid", 32'(exit_valid_o), 32'd0);
        check("rst_exit_code", exit_code_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("idle_gnt", 32'(gnt_o), 32'd0);

        // requests outside the window are ignored
        req = 1'b1; addr = 32'h9000_0004; #1;
        check("unsel_gnt", 32'(gnt_o), 32'd0);
        addr = 32'h8000_0010; #1;
        check("unsel_gnt_edge", 32'(gnt_o), 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        check("unsel_rvalid", 32'(rvalid_o), 32'd0);

        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("status_init", rd, 32'h1);
        bus_op(1'b0, A_PRINT, 0, 4'hF, rd);
        check("free_init", rd, 32'd16);

        // test 1: "Hi" with ready high
        char_ready = 1'b1;
        bus_op(1'b1, A_PRINT, 32'h48, 4'h1, rd);
        check("print_rdata_zero", rd, 32'd0);
        check("h_valid", 32'(char_valid_o), 32'd1);
        check("h_char", 32'(char_o), 32'h48);
        bus_op(1'b1, A_PRINT, 32'h69, 4'h1, rd);
        check("i_valid", 32'(char_valid_o), 32'd1);
        check("i_char", 32'(char_o), 32'h69);
        @(posedge clk); #1;
        check("hi_drained", 32'(char_valid_o), 32'd0);

        // be[0]=0 store is accepted but pushes nothing
        bus_op(1'b1, A_PRINT, 32'h55, 4'hE, rd);
        check("nobe_valid", 32'(char_valid_o), 32'd0);

        // test 2: fill FIFO with ready low, 17th store stalls
        char_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_op(1'b1, A_PRINT, 32'h41 + 32'(i), 4'h1, rd);
        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("status_full", rd, 32'h2);
        req = 1'b1; we = 1'b1; addr = A_PRINT; wdata = 32'h51; be = 4'h1; #1;
        check("full_gnt", 32'(gnt_o), 32'd0);
        @(posedge clk); #1;
        check("full_gnt_hold", 32'(gnt_o), 32'd0);
        check("full_no_rvalid", 32'(rvalid_o), 32'd0);
        check("full_head", 32'(char_o), 32'h41);
        char_ready = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        check("after_pop_gnt", 32'(gnt_o), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check("store17_rvalid", 32'(rvalid_o), 32'd1);
        bus_op(1'b0, A_PRINT, 0, 4'hF, rd);
        check("free_full", rd, 32'd0);
        char_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(char_o), 32'h41 + 32'(i));
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(char_valid_o), 32'd0);
        bus_op(1'b0, A_PRINT, 0, 4'hF, rd);
        check("free_empty", rd, 32'd16);

        // test 5a: cycle counter advances 10 in 10 cycles
        bus_op(1'b0, A_CYCLE, 0, 4'hF, rd);
        repeat (9) @(posedge clk);
        #1;
        bus_op(1'b0, A_CYCLE, 0, 4'hF, rd2);
        check("cycle_delta", rd2 - rd, 32'd10);

        // test 3: exit with 3 buffered chars
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_op(1'b1, A_PRINT, 32'h61 + 32'(i), 4'h1, rd);
        bus_op(1'b1, A_EXIT, 32'h0, 4'hF, rd);
        repeat (3) @(posedge clk);
        #1;
        check("drain_exit_valid", 32'(exit_valid_o), 32'd0);
        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("drain_status", rd, 32'h0);
        char_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("exit_char_%0d", i), 32'(char_o), 32'h61 + 32'(i));
            @(posedge clk); #1;
        end
        check("last_pop_empty", 32'(char_valid_o), 32'd0);
        check("last_pop_exit_valid", 32'(exit_valid_o), 32'd0);
        @(posedge clk); #1;
        check("done_exit_valid", 32'(exit_valid_o), 32'd1);
        check("done_exit_code", exit_code_o, 32'd0);

        // test 5b: counter frozen in DONE
        bus_op(1'b0, A_CYCLE, 0, 4'hF, rd);
        repeat (5) @(posedge clk);
        #1;
        bus_op(1'b0, A_CYCLE, 0, 4'hF, rd2);
        check("cycle_frozen", rd2, rd);
        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("done_status", rd, 32'h5);

        // test 4: first EXIT write wins
        do_reset();
        check("rst2_exit_valid", 32'(exit_valid_o), 32'd0);
        char_ready = 1'b0;
        bus_op(1'b1, A_PRINT, 32'h78, 4'h1, rd);
        bus_op(1'b1, A_EXIT, 32'd5, 4'hF, rd);
        bus_op(1'b1, A_EXIT, 32'd7, 4'hF, rd);
        check("exit_first_wins", exit_code_o, 32'd5);
        char_ready = 1'b1;
        n = 0;
        while (!exit_valid_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("exit5_valid", 32'(exit_valid_o), 32'd1);
        check("exit5_code", exit_code_o, 32'd5);
        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("exit5_status", rd, 32'h5);
        bus_op(1'b0, A_EXIT, 0, 4'hF, rd);
        check("exit5_read", rd, 32'd5);
        bus_op(1'b1, A_PRINT, 32'h7A, 4'h1, rd);
        @(posedge clk); #1;
        check("done_no_push", 32'(char_valid_o), 32'd0);

        // test 6: reset with chars buffered and a load in flight
        do_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_op(1'b1, A_PRINT, 32'h30 + 32'(i), 4'h1, rd);
        bus_op(1'b0, A_PRINT, 0, 4'hF, rd);
        check("free_4", rd, 32'd12);
        req = 1'b1; we = 1'b0; addr = A_STATUS; rst = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b0;
        check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_mid_char_valid", 32'(char_valid_o), 32'd0);
        bus_op(1'b0, A_STATUS, 0, 4'hF, rd);
        check("rst_mid_status", rd, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
